sar_ctrl_param: RTL and testbench
=================================

Name: sar_ctrl_param

Overview:
Parametrised successor to the fixed 8-bit SAR controller.
- Drives an external capacitive DAC and samples an external comparator.
- Adds a start/busy/done handshake, configurable sample and settle timing, and an input mux channel select.
- Sits between the analog front end (comparator, DAC, mux) and the digital readout logic in the top-level wrapper.

Parameters:
WIDTH, 8, conversion resolution in bits (2..16)
NUM_CH, 4, number of analog mux channels (1..16)
SAMPLE_CYC, 2, cycles the sample/track switch is held closed (>=1)
SETTLE_CYC, 1, cycles per bit trial before the comparator is sampled (>=1)
AVG_LOG2, 2, log2 of the number of averaged conversions (used only with SAR_AVG_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
start  in  1  request a conversion; accepted only in IDLE
ch_sel  in  CH_W=max(1,clog2(NUM_CH))  channel to convert; latched on accept
comp  in  1  comparator output; 1 = input >= DAC voltage, so the trial bit is kept
dac_code  out  WIDTH  current trial code to the DAC
mux_sel  out  CH_W  analog mux select, held for the whole conversion
sample  out  1  track/hold switch; high while tracking
busy  out  1  high from the accept cycle+1 until done
done  out  1  one-cycle pulse; result is valid from this cycle
result  out  WIDTH  last completed code, held until the next done
result_ch  out  CH_W  channel of result

Behaviour:
- Synchronous active-low reset on the clk posedge; rst_n is fixed to this polarity and synchronicity.
- Reset values: state=IDLE, dac_code=0, mux_sel=0, sample=0, busy=0, done=0, result=0, result_ch=0.
- States:
  - IDLE -> SAMPLE -> CONVERT -> DONE -> IDLE.
  - SAMPLE->CONVERT after SAMPLE_CYC cycles; CONVERT->DONE after WIDTH*SETTLE_CYC cycles; DONE->IDLE unconditionally.
- IDLE:
  - start=1 at a clock edge accepts the request; that is cycle 0.
  - ch_sel is latched into mux_sel.
  - An out-of-range ch_sel (>=NUM_CH) is clamped to NUM_CH-1.
- SAMPLE, cycles 1..SAMPLE_CYC:
  - sample=1, busy=1.
  - dac_code = 1<<(WIDTH-1), which pre-charges the MSB trial.
- CONVERT, bit i from WIDTH-1 down to 0:
  - dac_code = (decided upper bits) | (1<<i), held for SETTLE_CYC cycles.
  - On the last settle cycle, comp is registered as bit i.
  - The next trial sets bit i-1.
  - sample=0 throughout.
- DONE:
  - Occurs at cycle SAMPLE_CYC + WIDTH*SETTLE_CYC + 1 (cycle 11 with defaults).
  - done=1, result and result_ch update, busy=0, dac_code returns to 0.
- start while busy or in DONE is ignored; it is not queued.
- Back-to-back operation: start high in the cycle after DONE begins a new conversion with no gap beyond the IDLE cycle.
- rst_n low mid-conversion aborts immediately to the reset values. result is cleared, and no done is issued.
- comp is treated as synchronous and is not resynchronised inside this block.
- mux_sel is stable from cycle 1 to DONE.

Optional Feature:
Macro SAR_AVG_EN.
- Defined:
  - Each accepted start performs 2^AVG_LOG2 back-to-back SAMPLE+CONVERT passes on the same channel, with no IDLE in between.
  - Codes are summed in a WIDTH+AVG_LOG2 accumulator, cleared on accept.
  - result = accumulator >> AVG_LOG2 (truncating).
  - done pulses once, after the final pass.
  - busy stays high across all passes.
- Undefined: a single pass; AVG_LOG2 is ignored and no accumulator is synthesised.

Decomposition:
- Package sar_pkg holds:
  - the state enum (IDLE, SAMPLE, CONVERT, DONE);
  - the clog2-based CH_W derivation function;
  - a localparam for total conversion latency as a function of WIDTH, SAMPLE_CYC and SETTLE_CYC.
- One sub-module, sar_settle_timer:
  - a down-counter loaded with SAMPLE_CYC-1 or SETTLE_CYC-1;
  - asserts expire on zero;
  - reused for both the sample and the per-bit timing.

Test Plan:
- Comparator model comp=(V>=dac_code), V=0xA5, ch_sel=2, defaults -> done at cycle 11, result=0xA5, result_ch=2, mux_sel=2 during cycles 1..10, sample high on cycles 1-2 only.
- V=0x00, then V=0xFF, back-to-back starts -> results 0x00, then 0xFF; second done at cycle 23 relative to the first accept; dac_code trial sequence 0x80,0x40,...,0x01 for V=0x00.
- start pulsed at cycles 3 and 7 of a conversion -> ignored; a single done at cycle 11; busy continuous from 1 to 10.
- rst_n low at cycle 6 for one cycle -> all outputs return to reset values next edge; no done; a new start then gives a correct result.
- WIDTH=12, SETTLE_CYC=3, SAMPLE_CYC=4, V=0x5A3 -> done at cycle 41, result=0x5A3, each dac_code trial held 3 cycles.
- SAR_AVG_EN, AVG_LOG2=2, V per pass 0x40,0x41,0x42,0x43 -> one done at cycle 44, result=0x41.

Source files
------------

// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding, width helper and latency math for the SAR controller
package sar_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int conv_latency(input int width, input int sample_cyc, input int settle_cyc);
    return sample_cyc + width * settle_cyc + 1;
  endfunction
  localparam int DEF_LATENCY = conv_latency(8, 2, 1);
endpackage

// File: rtl/sar_settle_timer.sv
// sar_settle_timer: loadable down-counter, expire while the count sits at zero
module sar_settle_timer #(
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expire = cnt == '0;
endmodule

// File: rtl/sar_ctrl_param.sv
// sar_ctrl_param: parametrised SAR conversion controller with start/busy/done handshake
// Define SAR_AVG_EN to average 2^AVG_LOG2 back-to-back passes per request.
module sar_ctrl_param import sar_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 4,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 1,
  parameter int AVG_LOG2 = 2,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             comp,
  output logic [WIDTH-1:0] dac_code,
  output logic [CH_W-1:0]  mux_sel,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch
);
  localparam int BW = ch_w(WIDTH);
  localparam int TW = ch_w(SAMPLE_CYC > SETTLE_CYC ? SAMPLE_CYC : SETTLE_CYC);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  if (WIDTH < 2 || WIDTH > 16 || NUM_CH < 1 || NUM_CH > 16 || SAMPLE_CYC < 1 || SETTLE_CYC < 1 || AVG_LOG2 < 0) begin : g_bad_param
    $error("sar_ctrl_param: parameter out of range");
  end
  state_t state;
  logic [BW-1:0] bit_idx;
  logic [WIDTH-1:0] trial, kept, fin;
  logic [TW-1:0] load_val;
  logic load, expire, last_pass;
  always_comb begin
    trial = WIDTH'(1) << bit_idx;
    kept = comp ? dac_code : dac_code & ~trial;
    load = (state == IDLE && start) || ((state == SAMPLE || state == CONVERT) && expire) || (state == DONE && busy);
    load_val = (state == SAMPLE || state == CONVERT) ? TW'(SETTLE_CYC - 1) : TW'(SAMPLE_CYC - 1);
  end
  sar_settle_timer #(.TW(TW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .load_val(load_val),
    .expire(expire)
  );
`ifdef SAR_AVG_EN
  localparam int PW = AVG_LOG2 + 1;
  localparam logic [PW-1:0] LAST = PW'((1 << AVG_LOG2) - 1);
  logic [PW-1:0] pass;
  logic [WIDTH+AVG_LOG2-1:0] acc, acc_next;
  always_comb begin
    acc_next = acc + (WIDTH + AVG_LOG2)'(kept);
    last_pass = pass == LAST;
    fin = WIDTH'(acc_next >> AVG_LOG2);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      pass <= '0;
      acc <= '0;
    end else if (state == IDLE && start) begin
      pass <= '0;
      acc <= '0;
    end else if (state == CONVERT && expire && bit_idx == '0) begin
      pass <= pass + 1'b1;
      acc <= acc_next;
    end
`else
  assign last_pass = 1'b1;
  assign fin = kept;
`endif
  // DONE with busy still high is an inter-pass slot that re-enters SAMPLE
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      bit_idx <= '0;
      dac_code <= '0;
      mux_sel <= '0;
      sample <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      result_ch <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SAMPLE;
          mux_sel <= ch_sel > CH_LAST ? CH_LAST : ch_sel;
          sample <= 1'b1;
          busy <= 1'b1;
          dac_code <= MSB;
        end
        SAMPLE: if (expire) begin
          state <= CONVERT;
          sample <= 1'b0;
          bit_idx <= BW'(WIDTH - 1);
        end
        CONVERT: if (expire) begin
          if (bit_idx == '0) begin
            state <= DONE;
            dac_code <= '0;
            if (last_pass) begin
              done <= 1'b1;
              busy <= 1'b0;
              result <= fin;
              result_ch <= mux_sel;
            end
          end else begin
            dac_code <= kept | (trial >> 1);
            bit_idx <= bit_idx - 1'b1;
          end
        end
        DONE: if (busy) begin
          state <= SAMPLE;
          sample <= 1'b1;
          dac_code <= MSB;
        end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sar_ctrl_param.sv
// tb_sar_ctrl_param: directed checks of the SAR controller against an ideal comparator model
module tb_sar_ctrl_param;
  logic clk = 1'b0;
  logic rst_n;
  logic start0, comp0, samp0, busy0, done0;
  logic [1:0] ch0, mux0, rch0;
  logic [7:0] v0, dac0, res0;
  logic start1, comp1, samp1, busy1, done1;
  logic [1:0] ch1, mux1, rch1;
  logic [11:0] v1, dac1, res1;
  int tick = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;
  assign comp0 = v0 >= dac0;
  assign comp1 = v1 >= dac1;
  sar_ctrl_param u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ch_sel(ch0), .comp(comp0),
    .dac_code(dac0), .mux_sel(mux0), .sample(samp0), .busy(busy0), .done(done0),
    .result(res0), .result_ch(rch0)
  );
  sar_ctrl_param #(.WIDTH(12), .NUM_CH(3), .SAMPLE_CYC(4), .SETTLE_CYC(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ch_sel(ch1), .comp(comp1),
    .dac_code(dac1), .mux_sel(mux1), .sample(samp1), .busy(busy1), .done(done1),
    .result(res1), .result_ch(rch1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // one default-geometry conversion; returns tick of cycle 1 and of the done cycle
  task automatic conv0(input logic [7:0] v, input logic [1:0] ch, input bit chk_dac, input bit poke,
                       output int t_acc, output int t_done);
    int cyc;
    v0 = v;
    ch0 = ch;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    t_acc = tick;
    cyc = 1;
    while (!done0 && cyc < 40) begin
      check("sample", samp0, cyc <= 2);
      check("busy", busy0, 1);
      check("mux_sel", mux0, ch);
      if (chk_dac) check("dac_trial", dac0, cyc <= 2 ? 32'h80 : 32'h80 >> (cyc - 3));
      start0 = poke && (cyc == 3 || cyc == 7);
      step();
      cyc++;
    end
    start0 = 1'b0;
    t_done = tick;
    check("done_cycle", cyc, 11);
    check("result", res0, v);
    check("result_ch", rch0, ch);
    check("busy_at_done", busy0, 0);
    check("dac_at_done", dac0, 0);
  endtask
  initial begin
    int cyc, i, ta, td, ta1, td1, ta2, td2;
    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    ch0 = '0;
    ch1 = '0;
    v0 = '0;
    v1 = '0;
    repeat (2) step();
    check("rst_dac", dac0, 0);
    check("rst_mux", mux0, 0);
    check("rst_sample", samp0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_result", res0, 0);
    check("rst_result_ch", rch0, 0);
    check("rst_u1_dac", dac1, 0);
    rst_n = 1'b1;
    step();
`ifdef SAR_AVG_EN
    ch0 = 2'd1;
    v0 = 8'h40;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 100) begin
      v0 = 8'h40 + 8'((cyc - 1) / 11);
      check("avg_busy", busy0, 1);
      step();
      cyc++;
    end
    check("avg_done_cycle", cyc, 44);
    check("avg_result", res0, 8'h41);
    check("avg_result_ch", rch0, 1);
    step();
    check("avg_done_pulse", done0, 0);
`else
    conv0(8'hA5, 2'd2, 1'b0, 1'b0, ta, td);
    step();
    check("done_pulse", done0, 0);
    conv0(8'h00, 2'd1, 1'b1, 1'b0, ta1, td1);
    step();
    conv0(8'hFF, 2'd3, 1'b0, 1'b0, ta2, td2);
    check("b2b_second_done", td2 - ta1, 22);
    step();
    conv0(8'h3C, 2'd0, 1'b0, 1'b1, ta, td);
    step();
    check("ignored_start_idle", busy0, 0);
    v0 = 8'h77;
    ch0 = 2'd1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (5) step();
    check("pre_reset_busy", busy0, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_dac", dac0, 0);
    check("abort_mux", mux0, 0);
    check("abort_sample", samp0, 0);
    check("abort_busy", busy0, 0);
    check("abort_result", res0, 0);
    check("abort_result_ch", rch0, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      check("abort_no_done", done0, 0);
    end
    conv0(8'h5E, 2'd3, 1'b0, 1'b0, ta, td);
    v1 = 12'h5A3;
    ch1 = 2'd3;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 100) begin
      check("u1_mux_clamp", mux1, 2);
      check("u1_sample", samp1, cyc <= 4);
      if (cyc >= 5) begin
        i = 11 - (cyc - 5) / 3;
        check("u1_trial_bit", dac1 & ((32'd2 << i) - 1), 32'd1 << i);
        check("u1_upper_bits", dac1 >> (i + 1), v1 >> (i + 1));
      end else check("u1_msb_precharge", dac1, 12'h800);
      step();
      cyc++;
    end
    check("u1_done_cycle", cyc, 41);
    check("u1_result", res1, 12'h5A3);
    check("u1_result_ch", rch1, 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
